// File: rtl/core_pkg.sv
// Shared definitions for the core front end: NOP encoding, IF/ID register layout,
// default IMEM size and the per-cycle fetch action.
package core_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam int          IMEM_DEPTH_DEFAULT = 64;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } if_id_t;

    // What the fetch stage does this cycle, after reset has been ruled out.
    typedef enum logic [1:0] {
        ACT_NORMAL   = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_OOB      = 2'd2,
        ACT_REDIRECT = 2'd3
    } fetch_act_e;

    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};

    function automatic fetch_act_e fetch_action(input logic redirect, input logic stall,
                                                input logic oob);
        if (redirect)   return ACT_REDIRECT;
        else if (stall) return ACT_STALL;
        else if (oob)   return ACT_OOB;
        else            return ACT_NORMAL;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch-stage event counters: normal-path captures and inserted bubbles.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetched_inc,
    input  logic        bubble_inc,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_bubbles_o
);

    logic [31:0] fetched_q;
    logic [31:0] bubbles_q;

    // Both counters wrap freely; a stall raises neither increment so they hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= 32'h0;
            bubbles_q <= 32'h0;
        end else begin
            if (fetched_inc) fetched_q <= fetched_q + 32'd1;
            if (bubble_inc)  bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_bubbles_o = bubbles_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, combinational IMEM address, IF/ID capture with
// stall, redirect and out-of-range handling. FETCH_PERF_EN adds event counters.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic        oob_o,
    output logic        misalign_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_bubbles_o
`endif
);

    // Only the word index is stored, so PC bits [1:0] are zero by construction.
    logic [29:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    logic        misalign_q, misalign_d;
    logic        oob;
    logic [31:0] pc_byte;
    fetch_act_e  act;

    assign pc_byte = {pc_q, 2'b00};
    assign oob     = (pc_q >= 30'(IMEM_DEPTH));
    assign act     = fetch_action(redirect_i, stall_i, oob);

    always_comb begin
        pc_d       = pc_q;
        if_id_d    = if_id_q;
        misalign_d = misalign_q;
        case (act)
            ACT_REDIRECT: begin
                pc_d    = redirect_pc_i[31:2];
                if_id_d = IF_ID_BUBBLE;
                if (redirect_pc_i[1:0] != 2'b00) misalign_d = 1'b1;
            end
            ACT_STALL: ;
            // Out of range: spin on the same PC until a redirect rescues it.
            ACT_OOB: if_id_d = IF_ID_BUBBLE;
            default: begin
                pc_d          = pc_q + 30'd1;
                if_id_d.valid = 1'b1;
                if_id_d.pc    = pc_byte;
                if_id_d.pc4   = pc_byte + 32'd4;
                if_id_d.instr = imem_instr_i;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC[31:2];
            if_id_q    <= IF_ID_BUBBLE;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_id_q    <= if_id_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_pc_o     = pc_byte;
    assign if_id_valid_o = if_id_q.valid;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_instr_o = if_id_q.instr;
    assign oob_o         = oob;
    assign misalign_o    = misalign_q;

`ifdef FETCH_PERF_EN
    logic fetched_inc;
    logic bubble_inc;

    assign fetched_inc = (act == ACT_NORMAL);
    assign bubble_inc  = (act == ACT_REDIRECT) || (act == ACT_OOB);

    fetch_perf_counters u_perf (
        .clk            (clk),
        .reset          (reset),
        .fetched_inc    (fetched_inc),
        .bubble_inc     (bubble_inc),
        .perf_fetched_o (perf_fetched_o),
        .perf_bubbles_o (perf_bubbles_o)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// compared against a transaction-level fetch model. Build with FETCH_PERF_EN for counters.
module tb_fetch_stage;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall_i, redirect_i;
    logic [31:0] redirect_pc_i, imem_pc_o, imem_instr_i;
    logic        if_id_valid_o, oob_o, misalign_o;
    logic [31:0] if_id_pc_o, if_id_pc4_o, if_id_instr_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_o, perf_bubbles_o;
`endif

    logic [31:0] mem [DEPTH];

    always #5 clk = ~clk;

    // Combinational IMEM; out-of-range reads return junk that must never be captured.
    assign imem_instr_i = (imem_pc_o[31:2] < DEPTH) ? mem[imem_pc_o[7:2]] : 32'hDEAD_BEEF;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_pc_o     (imem_pc_o),
        .imem_instr_i  (imem_instr_i),
        .if_id_valid_o (if_id_valid_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_instr_o (if_id_instr_o),
        .oob_o         (oob_o),
        .misalign_o    (misalign_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o(perf_fetched_o),
        .perf_bubbles_o(perf_bubbles_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid, m_mis;
    int unsigned m_fet, m_bub;

    function automatic void m_bubble();
        m_valid = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
    endfunction

    // Drive one cycle of inputs, advance the model by the fetch rules, wait past the edge.
    task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] t);
        reset = r; stall_i = s; redirect_i = d; redirect_pc_i = t;
        if (r) begin
            m_pc = 32'h0; m_bubble(); m_mis = 1'b0; m_fet = 0; m_bub = 0;
        end else if (d) begin
            m_pc = (t / 4) * 4; m_bubble(); m_bub++;
            if (t % 4 != 0) m_mis = 1'b1;
        end else if (s) begin
        end else if (m_pc / 4 >= DEPTH) begin
            m_bubble(); m_bub++;
        end else begin
            m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = mem[m_pc / 4];
            m_fet++; m_pc = m_pc + 32'd4;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) cycle(1, 0, 0, 0);
        n_checks++;
        if (imem_pc_o !== 32'h0 || if_id_valid_o !== 1'b0 || if_id_pc_o !== 32'h0 ||
            if_id_pc4_o !== 32'h0 || if_id_instr_o !== NOP || misalign_o !== 1'b0 || oob_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h v=%b ipc=%h ipc4=%h instr=%h mis=%b oob=%b, want 0/0/0/0/00000013/0/0",
                     imem_pc_o, if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, misalign_o, oob_o);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h0000_0000; exp_instr[1] = 32'h0050_0113; exp_instr[2] = 32'h00C0_0193;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            n_checks++;
            if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'(i * 4) || if_id_instr_o !== exp_instr[i] ||
                imem_pc_o !== 32'(i * 4 + 4)) begin
                n_fail++;
                $display("FAIL seq_fetch_%0d: got v=%b pc=%h instr=%h next=%h, want v=1 pc=%h instr=%h next=%h",
                         i, if_id_valid_o, if_id_pc_o, if_id_instr_o, imem_pc_o, i * 4, exp_instr[i], i * 4 + 4);
            end
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < DEPTH && m_pc != 32'h48; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h4C);
        n_checks++;
        if (imem_pc_o !== 32'h4C || if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP || if_id_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL redirect_bubble: got pc=%h v=%b instr=%h ipc=%h, want 4c/0/00000013/0",
                     imem_pc_o, if_id_valid_o, if_id_instr_o, if_id_pc_o);
        end
        cycle(0, 0, 0, 0);
        n_checks++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h4C || if_id_pc4_o !== 32'h50 ||
            if_id_instr_o !== 32'h0091_0133) begin
            n_fail++;
            $display("FAIL redirect_target: got v=%b pc=%h pc4=%h instr=%h, want 1/4c/50/00910133",
                     if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o);
        end
    endtask

    task automatic test_stall();
        cycle(0, 0, 1, 32'h10);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 0);
            n_checks++;
            if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h10 || if_id_instr_o !== 32'h0023_E233 ||
                imem_pc_o !== 32'h14) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b ipc=%h instr=%h pc=%h, want 1/10/0023e233/14",
                         i, if_id_valid_o, if_id_pc_o, if_id_instr_o, imem_pc_o);
            end
        end
        cycle(0, 1, 1, 32'h24);
        n_checks++;
        if (imem_pc_o !== 32'h24 || if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP) begin
            n_fail++;
            $display("FAIL stall_redirect: got pc=%h v=%b instr=%h, want 24/0/00000013",
                     imem_pc_o, if_id_valid_o, if_id_instr_o);
        end
    endtask

    task automatic test_misalign_oob();
        cycle(0, 0, 1, 32'h102);
        n_checks++;
        if (imem_pc_o !== 32'h100 || misalign_o !== 1'b1 || oob_o !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_set: got pc=%h mis=%b oob=%b, want 100/1/1", imem_pc_o, misalign_o, oob_o);
        end
        repeat (3) begin
            cycle(0, 0, 0, 0);
            n_checks++;
            if (imem_pc_o !== 32'h100 || if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP || oob_o !== 1'b1) begin
                n_fail++;
                $display("FAIL oob_spin: got pc=%h v=%b instr=%h oob=%b, want 100/0/00000013/1",
                         imem_pc_o, if_id_valid_o, if_id_instr_o, oob_o);
            end
        end
        cycle(0, 0, 1, 32'h8);
        cycle(0, 0, 0, 0);
        n_checks++;
        if (misalign_o !== 1'b1 || if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h8) begin
            n_fail++;
            $display("FAIL misalign_sticky: got mis=%b v=%b ipc=%h, want 1/1/8", misalign_o, if_id_valid_o, if_id_pc_o);
        end
        cycle(1, 0, 1, 32'h3);
        n_checks++;
        if (misalign_o !== 1'b0 || imem_pc_o !== 32'h0 || if_id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_over_redirect: got mis=%b pc=%h v=%b, want 0/0/0", misalign_o, imem_pc_o, if_id_valid_o);
        end
    endtask

    task automatic test_edge_oob();
        cycle(0, 0, 1, 32'hFC);
        cycle(0, 0, 0, 0);
        n_checks++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'hFC || if_id_pc4_o !== 32'h100 ||
            imem_pc_o !== 32'h100 || oob_o !== 1'b1) begin
            n_fail++;
            $display("FAIL last_word: got v=%b ipc=%h pc4=%h pc=%h oob=%b, want 1/fc/100/100/1",
                     if_id_valid_o, if_id_pc_o, if_id_pc4_o, imem_pc_o, oob_o);
        end
        cycle(0, 0, 0, 0);
        n_checks++;
        if (if_id_valid_o !== 1'b0 || imem_pc_o !== 32'h100) begin
            n_fail++;
            $display("FAIL past_end_bubble: got v=%b pc=%h, want 0/100", if_id_valid_o, imem_pc_o);
        end
        cycle(0, 0, 1, 32'h0);
        cycle(0, 0, 0, 0);
        n_checks++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0 || oob_o !== 1'b0 || imem_pc_o !== 32'h4) begin
            n_fail++;
            $display("FAIL oob_recover: got v=%b ipc=%h oob=%b pc=%h, want 1/0/0/4",
                     if_id_valid_o, if_id_pc_o, oob_o, imem_pc_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic r, s, d;
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 9) == 0);
            cycle(r, s, d, $urandom_range(0, 32'h11F));
            n_checks++;
            if ({imem_pc_o, if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, oob_o, misalign_o} !==
                {m_pc, m_valid, m_ipc, m_ipc4, m_instr, (m_pc / 4 >= DEPTH), m_mis}) begin
                n_fail++;
                $display("FAIL random_%0d: got pc=%h v=%b ipc=%h pc4=%h instr=%h oob=%b mis=%b, want pc=%h v=%b ipc=%h pc4=%h instr=%h mis=%b",
                         i, imem_pc_o, if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, oob_o, misalign_o,
                         m_pc, m_valid, m_ipc, m_ipc4, m_instr, m_mis);
            end
`ifdef FETCH_PERF_EN
            n_checks++;
            if (perf_fetched_o !== m_fet || perf_bubbles_o !== m_bub) begin
                n_fail++;
                $display("FAIL random_perf_%0d: got fet=%0d bub=%0d, want fet=%0d bub=%0d",
                         i, perf_fetched_o, perf_bubbles_o, m_fet, m_bub);
            end
`endif
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        cycle(1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0);
        repeat (5) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 32'h20);
        n_checks++;
        if (perf_fetched_o !== 32'd10 || perf_bubbles_o !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_counts: got fet=%0d bub=%0d, want 10/2", perf_fetched_o, perf_bubbles_o);
        end
        cycle(1, 0, 0, 0);
        n_checks++;
        if (perf_fetched_o !== 32'd0 || perf_bubbles_o !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got fet=%0d bub=%0d, want 0/0", perf_fetched_o, perf_bubbles_o);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0]  = 32'h0000_0000;
        mem[1]  = 32'h0050_0113;
        mem[2]  = 32'h00C0_0193;
        mem[4]  = 32'h0023_E233;
        mem[19] = 32'h0091_0133;
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_misalign_oob();
        test_edge_oob();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
